// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types and requester indices for the register-file write port.
// Latency: none (declarations only).
// Backpressure: n/a.
package alioth_wb_pkg;

   // Default register width for the shared request record.
   localparam int WB_XLEN = 32;

   // Fixed requester slots on the writeback port.
   localparam int WB_IDX_ALU = 0;
   localparam int WB_IDX_MUL = 1;
   localparam int WB_IDX_DIV = 2;
   localparam int WB_IDX_LSU = 3;

   // Payload carried by one writeback request.
   typedef struct packed {
      logic [4:0]         waddr;
      logic [WB_XLEN-1:0] wdata;
   } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle between the execution units, the writeback arbiter and the register file / HDU.
// Latency: none (wires only).
// Backpressure: requesters hold valid and payload until req_ready_o; the register-file side cannot stall.
// Ports: req_valid_i/req_waddr_i/req_wdata_i (units -> arbiter), req_ready_o, reg_we_o/reg_waddr_o/reg_wdata_o,
//        wb_done_o, wb_prepared_o, grant_idx_o (arbiter -> units / RF / HDU).
interface wb_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int XLEN    = 32,
   parameter int IDX_W   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]      req_valid_i;
   logic [NUM_REQ*5-1:0]    req_waddr_i;
   logic [NUM_REQ*XLEN-1:0] req_wdata_i;
   logic [NUM_REQ-1:0]      req_ready_o;
   logic                    reg_we_o;
   logic [4:0]              reg_waddr_o;
   logic [XLEN-1:0]         reg_wdata_o;
   logic                    wb_done_o;
   logic                    wb_prepared_o;
   logic [IDX_W-1:0]        grant_idx_o;

   // Requester / observer side.
   modport master (
      output req_valid_i, req_waddr_i, req_wdata_i,
      input  req_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o,
             wb_done_o, wb_prepared_o, grant_idx_o
   );

   // Arbiter side.
   modport slave (
      input  req_valid_i, req_waddr_i, req_wdata_i,
      output req_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o,
             wb_done_o, wb_prepared_o, grant_idx_o
   );
endinterface

// File: rtl/wb_arbiter_rr.sv
// One-hot grant generator for the writeback port: round-robin, or fixed lowest-index priority
// when WB_ARB_FIXED_PRIO_EN is defined. Latency: grant is combinational from req_valid_i.
// Backpressure: a requester without a grant simply keeps valid high and is reconsidered next cycle.
// Ports: clk, rst_n; req_valid_i in; grant_o (one-hot), grant_idx_o, grant_vld_o out.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               grant_vld_o
);

   logic [IDX_W-1:0] start;
   int               cand;

`ifdef WB_ARB_FIXED_PRIO_EN
   // Search always begins at requester 0, so the lowest index wins; no pointer state.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;
   assign start          = '0;
`else
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W:0]   ptr_inc;

   // One extra bit so that winner+1 == NUM_REQ is detectable for any NUM_REQ.
   assign ptr_inc = {1'b0, grant_idx_o} + (IDX_W+1)'(1);
   assign start   = rr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (grant_vld_o) begin
         rr_ptr <= (ptr_inc == (IDX_W+1)'(NUM_REQ)) ? '0 : ptr_inc[IDX_W-1:0];
      end
   end
`endif

   // Walk NUM_REQ slots starting at 'start', wrapping; first valid slot wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      cand        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(start) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!grant_vld_o && req_valid_i[cand]) begin
            grant_vld_o   = 1'b1;
            grant_o[cand] = 1'b1;
            grant_idx_o   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the single register-file write port among NUM_REQ execution units and registers the winner.
// Latency: grant/ready/wb_prepared same cycle; reg_we/waddr/wdata and wb_done one cycle after the grant.
// Backpressure: losers hold valid and retry; the register file never stalls the output register.
// Ports: clk, rst_n (async, active-low), bus (wb_arbiter_if.slave).
// Build option: define WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module wb_arbiter
   import alioth_wb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int XLEN    = 32,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic        clk,
   input  logic        rst_n,
   wb_arbiter_if.slave bus
);

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_vld;
   logic [4:0]         sel_waddr;
   logic [XLEN-1:0]    sel_wdata;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (bus.req_valid_i),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .grant_vld_o (grant_vld)
   );

   assign bus.req_ready_o   = grant;
   assign bus.wb_prepared_o = grant_vld;
   assign bus.grant_idx_o   = grant_idx;

   // AND-OR payload mux driven by the one-hot grant.
   always_comb begin
      sel_waddr = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_waddr = sel_waddr | bus.req_waddr_i[5*i +: 5];
            sel_wdata = sel_wdata | bus.req_wdata_i[XLEN*i +: XLEN];
         end
      end
   end

   // Address/data hold when idle; only the strobes return to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.reg_we_o    <= 1'b0;
         bus.reg_waddr_o <= '0;
         bus.reg_wdata_o <= '0;
         bus.wb_done_o   <= 1'b0;
      end else if (grant_vld) begin
         bus.reg_we_o    <= (sel_waddr != 5'd0);  // x0 retires without writing
         bus.reg_waddr_o <= sel_waddr;
         bus.reg_wdata_o <= sel_wdata;
         bus.wb_done_o   <= 1'b1;
      end else begin
         bus.reg_we_o    <= 1'b0;
         bus.wb_done_o   <= 1'b0;
      end
   end

endmodule
